seq_mult_dsr: RTL and testbench
===============================

# seq_mult_dsr

Parametrised digit-serial sequential multiplier: multiplies two WIDTH-bit operands using one DIGIT x DIGIT multiplier, accumulating one shifted partial product per clock. It is the general successor of the fixed 8-bit, 4x4-digit shift-add multiplier. It adds a ready/busy handshake, start-while-busy protection and an optional signed mode. It sits between the operand input registers and the result/display logic of the arithmetic datapath.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT, and WIDTH >= DIGIT
- DIGIT, 4, digit width of the single hardware multiplier
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  multiplicand, captured when start is accepted
- b  in  WIDTH  multiplier, captured when start is accepted
- ready  out  1  high in IDLE; reset value 1
- busy  out  1  high in CALC/NEG/DONE; reset value 0
- done  out  1  one-cycle pulse when d_out is updated; reset value 0
- d_out  out  2*WIDTH  registered product, held until the next done; reset value 0

## Operation
- N = WIDTH/DIGIT; P = N*N partial products. Digit counters are i (a digit) and j (b digit), each 0..N-1. j is the inner loop.
- IDLE: when start=1, capture a and b into internal registers and clear acc (2*WIDTH bits). Set i=j=0 and go to CALC. When start=0, remain in IDLE.
- CALC: each cycle, acc += (a_digit[i] * b_digit[j]) << (DIGIT*(i+j)). Arithmetic is modulo 2^(2*WIDTH); overflow cannot occur for unsigned operands.
- CALC to DONE happens after the cycle with i=j=N-1.
- DONE: d_out <= acc, done=1 for this single cycle, then go to IDLE.
- start while busy is ignored. Captured operands are not disturbed, and no request is queued.
- a and b may change freely after acceptance.
- rst in any state forces IDLE on the next edge. It clears acc, the counters and d_out, and sets done=0, ready=1, busy=0. An in-flight result is discarded.
- start and rst asserted together: rst wins.
- Degenerate case N=1 (WIDTH=DIGIT): P=1, giving a single CALC cycle.

## Timing
- Edge 0: start is sampled in IDLE. Edges 1..P: CALC accumulations. Edge P+1: DONE, with d_out valid and done high in the cycle following edge P+1.
- Unsigned latency from start acceptance to done is P+1 cycles. Signed mode adds 1 cycle (P+2).
- ready drops in the cycle after acceptance and returns in the cycle after done. Back-to-back operation: start may be asserted in the first ready cycle.
- Throughput: one result per P+2 cycles, or P+3 in signed mode.

## Configuration
- SEQ_MULT_DSR_SIGNED_EN defined:
  - Operands are two's complement.
  - At capture, the registers store |a| and |b| (WIDTH-bit unsigned, so -2^(WIDTH-1) is representable), and neg = a[MSB]^b[MSB].
  - A NEG state sits between CALC and DONE and sets acc <= neg ? -acc : acc.
  - d_out is the signed product.
- Not defined: operands are unsigned, no NEG state, latency P+1. No port differences in either mode.

## Structure
- Package seq_mult_dsr_pkg holds:
  - the state typedef (IDLE, CALC, NEG, DONE);
  - a function returning P for given WIDTH and DIGIT;
  - a digit-extract helper.
- NEG is present in the enum unconditionally and is unreachable when the macro is undefined.
- One sub-module, digit_mult: a combinational DIGIT x DIGIT to 2*DIGIT unsigned multiplier, instantiated once.
- Parameter legality (WIDTH % DIGIT == 0) is checked at elaboration.

## Test plan
- Directed scenarios use WIDTH=16, DIGIT=4 unless noted, so P=16.
- a=0xFFFF, b=0xFFFF -> d_out=0xFFFE0001, done exactly 17 cycles after start accepted, ready back next cycle.
- WIDTH=8, DIGIT=4: a=0xAB, b=0xCD -> d_out=0x88EF after 5 cycles. Then immediate back-to-back a=0, b=0x12 -> d_out=0x0000 with one done pulse each.
- a=0x1234, b=0x0010 accepted, then start pulsed with a=0xFFFF, b=0xFFFF at CALC cycle 5 -> ignored, d_out=0x00012340.
- rst asserted at CALC cycle 8 of a 0x00FF*0x00FF run -> next cycle ready=1, busy=0, done=0, d_out=0, and no done pulse ever follows.
- SEQ_MULT_DSR_SIGNED_EN: a=-3 (0xFFFD), b=5 -> d_out=0xFFFFFFF1 after 18 cycles; a=b=0x8000 -> d_out=0x40000000.

Source files
------------

// File: rtl/seq_mult_dsr_pkg.sv
// rtl/seq_mult_dsr_pkg.sv - shared types and helpers for the digit-serial multiplier
package seq_mult_dsr_pkg;

    // Widest operand the digit-extract helper can handle
    localparam int MAX_W = 64;

    // NEG is always declared; it is only entered when SEQ_MULT_DSR_SIGNED_EN is defined
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Number of partial products (accumulation cycles) for one multiply
    function automatic int num_pp(input int width, input int digit);
        return (width / digit) * (width / digit);
    endfunction

    // Returns digit number idx (dw bits wide, LSB first) of val, zero-extended
    function automatic logic [MAX_W-1:0] digit_of(input logic [MAX_W-1:0] val,
                                                  input int idx,
                                                  input int dw);
        logic [MAX_W-1:0] mask;
        mask = (MAX_W'(1) << dw) - MAX_W'(1);
        return (val >> (idx * dw)) & mask;
    endfunction

endpackage

// File: rtl/seq_mult_dsr_digit_mult.sv
// rtl/seq_mult_dsr_digit_mult.sv - combinational DIGIT x DIGIT unsigned multiplier
module digit_mult #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0]   x_i,
    input  logic [DIGIT-1:0]   y_i,
    output logic [2*DIGIT-1:0] p_o
);

    // Zero-extend both operands so the product keeps all 2*DIGIT bits
    assign p_o = {{DIGIT{1'b0}}, x_i} * {{DIGIT{1'b0}}, y_i};

endmodule

// File: rtl/seq_mult_dsr.sv
// rtl/seq_mult_dsr.sv - digit-serial shift-add multiplier, signed mode via SEQ_MULT_DSR_SIGNED_EN
module seq_mult_dsr
    import seq_mult_dsr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] d_out
);

    localparam int N  = WIDTH / DIGIT;
    localparam int P  = num_pp(WIDTH, DIGIT);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Reject illegal geometries before anything is built
    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT || WIDTH > MAX_W || P < 1) begin : g_param_check
        $error("seq_mult_dsr: WIDTH must be a multiple of DIGIT, >= DIGIT and <= MAX_W");
    end

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      i_q;
    logic [CW-1:0]      j_q;
`ifdef SEQ_MULT_DSR_SIGNED_EN
    logic               neg_q;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
`endif

    logic [DIGIT-1:0]   a_dig;
    logic [DIGIT-1:0]   b_dig;
    logic [2*DIGIT-1:0] prod;
    logic [2*WIDTH-1:0] pp_shift;

    // Select the current digit pair and align its product to weight DIGIT*(i+j)
    always_comb begin
        a_dig    = DIGIT'(digit_of(MAX_W'(a_q), int'(i_q), DIGIT));
        b_dig    = DIGIT'(digit_of(MAX_W'(b_q), int'(j_q), DIGIT));
        pp_shift = (2*WIDTH)'(prod) << (DIGIT * (int'(i_q) + int'(j_q)));
    end

    digit_mult #(
        .DIGIT (DIGIT)
    ) u_digit_mult (
        .x_i (a_dig),
        .y_i (b_dig),
        .p_o (prod)
    );

`ifdef SEQ_MULT_DSR_SIGNED_EN
    // Magnitudes held as WIDTH-bit unsigned so the most negative value stays representable
    always_comb begin
        a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    end
`endif

    // Control FSM with the accumulator, digit counters and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            d_out   <= '0;
            done    <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
`ifdef SEQ_MULT_DSR_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
`ifdef SEQ_MULT_DSR_SIGNED_EN
                        a_q   <= a_mag;
                        b_q   <= b_mag;
                        neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
`else
                        a_q   <= a;
                        b_q   <= b;
`endif
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        state_q <= CALC;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                CALC: begin
                    acc_q <= acc_q + pp_shift;
                    if (j_q == LAST) begin
                        j_q <= '0;
                        if (i_q == LAST) begin
                            i_q <= '0;
`ifdef SEQ_MULT_DSR_SIGNED_EN
                            state_q <= NEG;
`else
                            state_q <= DONE;
`endif
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                NEG: begin
`ifdef SEQ_MULT_DSR_SIGNED_EN
                    acc_q <= neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
`endif
                    state_q <= DONE;
                end
                DONE: begin
                    d_out   <= acc_q;
                    done    <= 1'b1;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_dsr.sv
// tb/tb_seq_mult_dsr.sv - directed self-checking bench for seq_mult_dsr
module tb_seq_mult_dsr;

`ifdef SEQ_MULT_DSR_SIGNED_EN
    localparam int LAT16 = 18;
    localparam int LAT8  = 6;
    localparam logic [31:0] EXP_FFFF_SQ = 32'h0000_0001;
    localparam logic [31:0] EXP_M3_X5   = 32'hFFFF_FFF1;
    localparam logic [15:0] EXP_AB_CD   = 16'h10EF;
`else
    localparam int LAT16 = 17;
    localparam int LAT8  = 5;
    localparam logic [31:0] EXP_FFFF_SQ = 32'hFFFE_0001;
    localparam logic [31:0] EXP_M3_X5   = 32'h0004_FFF1;
    localparam logic [15:0] EXP_AB_CD   = 16'h88EF;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        ready16;
    logic        busy16;
    logic        done16;
    logic [31:0] dout16;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        ready8;
    logic        busy8;
    logic        done8;
    logic [15:0] dout8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_mult_dsr #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .ready (ready16),
        .busy  (busy16),
        .done  (done16),
        .d_out (dout16)
    );

    seq_mult_dsr #(.WIDTH(8), .DIGIT(4)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .ready (ready8),
        .busy  (busy8),
        .done  (done8),
        .d_out (dout8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present operands and start for one edge on the 16-bit unit
    task automatic start_16(input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        check("rdy_before_start", 64'(ready16), 64'd1);
        a16 = av;
        b16 = bv;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        a16 = $urandom;
        b16 = $urandom;
        check("busy_after_start", 64'(busy16), 64'd1);
        check("rdy_after_start", 64'(ready16), 64'd0);
    endtask

    // Count edges until done; already_edges are edges since acceptance already consumed
    task automatic wait_done_16(input string tag, input logic [31:0] exp, input int lat,
                                input int already_edges);
        int n = already_edges;
        bit seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (done16) seen = 1'b1;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_dout"}, 64'(dout16), 64'(exp));
        check({tag, "_rdy"}, 64'(ready16), 64'd1);
        check({tag, "_busy"}, 64'(busy16), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(done16), 64'd0);
        check({tag, "_dout_hold"}, 64'(dout16), 64'(exp));
    endtask

    initial begin
        int n;
        int pulses;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready16", 64'(ready16), 64'd1);
        check("rst_busy16", 64'(busy16), 64'd0);
        check("rst_done16", 64'(done16), 64'd0);
        check("rst_dout16", 64'(dout16), 64'd0);
        check("rst_ready8", 64'(ready8), 64'd1);
        check("rst_dout8", 64'(dout8), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        start_16(16'hFFFF, 16'hFFFF);
        wait_done_16("ffff_sq", EXP_FFFF_SQ, LAT16, 0);

        start_16(16'hFFFD, 16'h0005);
        wait_done_16("m3_x5", EXP_M3_X5, LAT16, 0);

        start_16(16'h8000, 16'h8000);
        wait_done_16("min_sq", 32'h4000_0000, LAT16, 0);

        // start pulsed mid-calculation must be ignored
        start_16(16'h1234, 16'h0010);
        repeat (4) @(posedge clk);
        @(negedge clk);
        a16 = 16'hFFFF;
        b16 = 16'hFFFF;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        wait_done_16("busy_start", 32'h0001_2340, LAT16, 5);

        // reset in CALC cycle 8 discards the result
        start_16(16'h00FF, 16'h00FF);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_ready", 64'(ready16), 64'd1);
        check("mid_rst_busy", 64'(busy16), 64'd0);
        check("mid_rst_done", 64'(done16), 64'd0);
        check("mid_rst_dout", 64'(dout16), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done16) pulses++;
        end
        check("mid_rst_no_done", 64'(pulses), 64'd0);

        // 8-bit unit, back-to-back with start held high
        @(negedge clk);
        a8 = 8'hAB;
        b8 = 8'hCD;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        a8 = 8'h00;
        b8 = 8'h12;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (done8) seen = 1'b1;
        end
        check("w8_first_lat", 64'(n), 64'(LAT8));
        check("w8_first_dout", 64'(dout8), 64'(EXP_AB_CD));
        check("w8_first_rdy", 64'(ready8), 64'd1);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        check("w8_b2b_accept", 64'(busy8), 64'd1);
        check("w8_b2b_done_low", 64'(done8), 64'd0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (done8) seen = 1'b1;
        end
        check("w8_second_lat", 64'(n), 64'(LAT8));
        check("w8_second_dout", 64'(dout8), 64'd0);
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done8) pulses++;
        end
        check("w8_no_extra_done", 64'(pulses), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
